// File: rtl/iterative_aes_decoder.sv
// ============================================================================
// iterative_aes_decoder : AES-128 decryption, one inverse round per clock
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module iterative_aes_decoder #(
    parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    // Byte 0x00 sits in the top byte, so entry b is found at index ~b.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ADDKEY = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[~b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[~b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step: recover the three trailing words first, then w0.
    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^
               (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
            end
        end
        t = t ^ k;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
            end
        end
        return t;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] rk_prev;
    logic [127:0] round_res;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        // In ROUND, cnt is r and rk holds K(r+1); the step back yields Kr.
        rk_prev     = inv_key(rk_q, rcon(cnt_q + 4'd1));
        round_res   = inv_round(st_q, rk_prev, cnt_q == 4'd0);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in;
                    rk_d    = key;
                    cnt_d   = 4'd1;
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d  = fwd_key(rk_q, rcon(cnt_q));
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_RND) begin
                    state_d = ADDKEY;
                end
            end
            ADDKEY: begin
                st_d    = st_q ^ rk_q;
                cnt_d   = LAST_RND - 4'd1;
                state_d = ROUND;
            end
            ROUND: begin
                st_d = round_res;
                rk_d = rk_prev;
                if (cnt_q == 4'd0) begin
                    out_d       = round_res;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_aes_decoder.sv
// ============================================================================
// tb_iterative_aes_decoder : directed + randomized bench for the AES decoder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_aes_decoder;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] tb_in = '0;
    logic [127:0] tb_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] tb_out;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [256];

    iterative_aes_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (tb_in),
        .key       (tb_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (tb_out),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference encoder, with its S-box derived from GF(2^8) inversion.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] rk, s, t;
        logic [31:0]  w0, w1, w2, w3, tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = k;
        s  = p ^ k;
        rc = 8'h01;
        t  = '0;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[127-8*(r+4*c) -: 8] = sb[s[127-8*(r+4*((c+r)%4)) -: 8]];
            s = t;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = t[127-32*c -: 32];
                    s[127-32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                                         gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
                end
            end
            {w0, w1, w2, w3} = rk;
            tmp = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h000000};
            w0 = w0 ^ tmp;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rk = {w0, w1, w2, w3};
            rc = gm(rc, 8'h02);
            s  = s ^ rk;
        end
        return s;
    endfunction

    task automatic send(input string tag, input logic [127:0] k, input logic [127:0] c);
        int n;
        tb_key   = k;
        tb_in    = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk1({tag, "_accept"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    // Full directed decrypt with out_ready held high; checks exact latency.
    task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] p, input bit chk_rk, input bit scramble);
        out_ready = 1'b1;
        send(tag, k, c);
        chk1({tag, "_busy"}, busy, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            if (scramble) begin
                tb_in  = rnd128();
                tb_key = rnd128();
            end
            step();
            if (chk_rk && i == 10) chk({tag, "_k10"}, dut.rk_q, K10_C1);
        end
        chk1({tag, "_early"}, out_valid, 1'b0);
        step();
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_out"}, tb_out, p);
        step();
        chk1({tag, "_drop"}, out_valid, 1'b0);
        chk1({tag, "_idle_rdy"}, in_ready, 1'b1);
        chk({tag, "_retain"}, tb_out, p);
    endtask

    task automatic check_reset_state(input string tag);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_out"}, tb_out, 128'd0);
        chk1({tag, "_rdy"}, in_ready, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [127:0] pt, kk, got;
        logic [7:0]   inv, s;
        logic         done;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end

        // Reset state
        reset = 1'b1;
        step();
        step();
        check_reset_state("rst");
        chk("rst_rk", dut.rk_q, 128'd0);
        chk("rst_st", dut.st_q, 128'd0);
        chk({124'd0, dut.cnt_q}, 128'd0, 128'd0) ;
        reset = 1'b0;
        step();

        // FIPS-197 vectors, then again with inputs changing every cycle
        run_vec("c1", K_C1, CT_C1, PT_C1, 1'b1, 1'b0);
        run_vec("appb", K_B, CT_B, PT_B, 1'b0, 1'b0);
        run_vec("stable", K_C1, CT_C1, PT_C1, 1'b0, 1'b1);

        // Backpressure with a competing request held on the input
        out_ready = 1'b0;
        send("bp", K_C1, CT_C1);
        repeat (21) step();
        chk1("bp_valid", out_valid, 1'b1);
        chk("bp_out", tb_out, PT_C1);
        tb_key   = K_B;
        tb_in    = CT_B;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("bp_hold_out", tb_out, PT_C1);
            chk1("bp_hold_valid", out_valid, 1'b1);
            chk1("bp_hold_rdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("bp_rel_valid", out_valid, 1'b0);
        chk1("bp_rel_rdy", in_ready, 1'b1);
        chk1("bp_rel_busy", busy, 1'b0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (21) step();
        chk1("bp_b_valid", out_valid, 1'b1);
        chk("bp_b_out", tb_out, PT_B);
        step();

        // Reset during KEYEXP and during ROUND
        send("mr8", K_C1, CT_C1);
        repeat (7) step();
        reset = 1'b1;
        step();
        check_reset_state("mr8");
        reset = 1'b0;
        send("mr15", K_C1, CT_C1);
        repeat (14) step();
        reset = 1'b1;
        step();
        check_reset_state("mr15");
        reset = 1'b0;
        run_vec("b_after_rst", K_B, CT_B, PT_B, 1'b0, 1'b0);

        // Random vectors through the reference encoder, random gaps/backpressure
        for (int n = 0; n < 100; n++) begin
            pt = rnd128();
            kk = rnd128();
            in_valid  = 1'b0;
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            send("b2b", kk, aes_enc(kk, pt));
            done = 1'b0;
            got  = '0;
            for (int c = 0; c < 200 && !done; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    got  = tb_out;
                    done = 1'b1;
                end
                step();
            end
            out_ready = 1'b0;
            chk1("b2b_handshake", done, 1'b1);
            chk("b2b_out", got, pt);
            chk1("b2b_no_dup", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
